// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback controller.
// Widths normally come from the project's defines.v; the fallbacks keep this slice self-contained.
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 4
`endif
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif

package wb_pkg;
    localparam int NUM_REGS_DEF = 12;
    localparam int ADDR_W       = `REG_FILE_ADDR_LEN;
    localparam int DATA_W       = `REG_FILE_SIZE;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] val;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_MEM,
        WB_FIFO,
        WB_ALU
    } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending ALU writeback entries; DEPTH must be a power of two.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write master: merges load and ALU results, one write per cycle, with a pending-write scoreboard.
// Build option WB_FWD_EN adds same-cycle forwarding of the commit candidate to the ID query ports.
module reg_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueDest,
    output logic              issueReady,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluDest,
    input  logic [DATA_W-1:0] aluVal,
    output logic              aluReady,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memDest,
    input  logic [DATA_W-1:0] memVal,
    output logic              writeEn,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] writeVal,
    input  logic [ADDR_W-1:0] query1,
    input  logic [ADDR_W-1:0] query2,
    output logic              busy1,
    output logic              busy2
`ifdef WB_FWD_EN
    ,
    output logic              fwd1Hit,
    output logic              fwd2Hit,
    output logic [DATA_W-1:0] fwd1Val,
    output logic [DATA_W-1:0] fwd2Val
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshakes: a transfer happens on a posedge where valid && ready; ready never depends on the
    // same port's valid, and an ALU producer must hold its payload stable until it is accepted.
    logic [CNT_W-1:0]          cnt [NUM_REGS];
    logic [NUM_REGS-1:0]       inc_vec;
    logic [NUM_REGS-1:0]       dec_vec;
    wb_src_e                   src;
    wb_entry_t                 cand;
    wb_entry_t                 fifo_dout;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_level_unused;
    logic                      commit;
    logic                      issue_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input logic [ADDR_W-1:0] a);
        return in_range(a) ? cnt[a] : '0;
    endfunction

    always_comb begin
        src  = WB_NONE;
        cand = '0;
        if (memValid) begin
            src  = WB_MEM;
            cand = '{dest: memDest, val: memVal};
        end else if (!fifo_empty) begin
            src  = WB_FIFO;
            cand = fifo_dout;
        end else if (aluValid) begin
            src  = WB_ALU;
            cand = '{dest: aluDest, val: aluVal};
        end
    end

    // Out-of-range entries are still consumed, they just never reach the register file.
    assign commit    = (src != WB_NONE) && in_range(cand.dest);
    assign aluReady  = !fifo_full;
    assign fifo_push = aluValid && aluReady && (src != WB_ALU);
    assign fifo_pop  = (src == WB_FIFO);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ('{dest: aluDest, val: aluVal}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_level_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeEn  <= 1'b0;
            dest     <= '0;
            writeVal <= '0;
        end else begin
            writeEn <= commit;
            if (commit) begin
                dest     <= cand.dest;
                writeVal <= cand.val;
            end
        end
    end

    assign issueReady = !in_range(issueDest) || (cnt_of(issueDest) != CNT_MAX)
                        || (commit && (cand.dest == issueDest));
    assign issue_ok   = issueValid && issueReady && in_range(issueDest);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_ok && (issueDest == ADDR_W'(i));
            dec_vec[i] = commit && (cand.dest == ADDR_W'(i));
        end
    end

    // The decrement lands on the same edge that raises writeEn, so busy drops in step with the negedge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd1Hit = commit && (cand.dest == query1) && (cnt_of(query1) == CNT_W'(1));
    assign fwd2Hit = commit && (cand.dest == query2) && (cnt_of(query2) == CNT_W'(1));
    assign fwd1Val = cand.val;
    assign fwd2Val = cand.val;
    assign busy1   = (cnt_of(query1) != '0) && !fwd1Hit;
    assign busy2   = (cnt_of(query2) != '0) && !fwd2Hit;
`else
    assign busy1   = (cnt_of(query1) != '0);
    assign busy2   = (cnt_of(query2) != '0);
`endif
endmodule
